tetris_input_ctrl: RTL and testbench

- Upstream command generator for the tetris core; drives its `ctrl` input.
- Turns raw board buttons into one-cycle `state_type` commands:
  - 2-FF synchronise, then debounce each button;
  - edge detect, with LEFT/RIGHT auto-repeat;
  - a level-scaled gravity timer injects DOWN.
- Events are queued as sticky pending bits and issued one at a time under a ready handshake.

---
 rtl/enum_type.sv | 51 +++++
 rtl/btn_debounce.sv | 46 ++++
 rtl/tetris_input_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enum_type.sv
`default_nettype none
// enum_type: command and arbiter encodings plus button/pending indices for tetris_input_ctrl.
// Revision: 1.0
package enum_type;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    DOWN   = 3'd3,
    ROTATE = 3'd4,
    DROP   = 3'd5,
    HOLD   = 3'd6
  } state_type;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

  localparam int unsigned NUM_BTN    = 5;
  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_ROTATE = 2;
  localparam int unsigned BTN_DROP   = 3;
  localparam int unsigned BTN_HOLD   = 4;

  // Pending bits are ordered so that a higher index wins arbitration.
  localparam int unsigned NUM_PEND    = 6;
  localparam int unsigned PEND_DOWN   = 0;
  localparam int unsigned PEND_RIGHT  = 1;
  localparam int unsigned PEND_LEFT   = 2;
  localparam int unsigned PEND_ROTATE = 3;
  localparam int unsigned PEND_DROP   = 4;
  localparam int unsigned PEND_HOLD   = 5;

  function automatic state_type pend_cmd(input int unsigned idx);
    case (idx)
      PEND_HOLD:   pend_cmd = HOLD;
      PEND_DROP:   pend_cmd = DROP;
      PEND_ROTATE: pend_cmd = ROTATE;
      PEND_LEFT:   pend_cmd = LEFT;
      PEND_RIGHT:  pend_cmd = RIGHT;
      PEND_DOWN:   pend_cmd = DOWN;
      default:     pend_cmd = NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// btn_debounce: 2-FF synchroniser plus counter debouncer; press pulses on the edge the level rises.
// Revision: 1.0
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip  = (sync2 != level) && (cnt == CNT_LAST);
  assign press = flip && sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if ((sync2 == level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (flip) begin
        level <= sync2;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tetris_input_ctrl.sv
`default_nettype none
// tetris_input_ctrl: buttons + gravity -> one-cycle commands under a ready handshake.
// Optional macro TETRIS_AUTOREPEAT_EN enables LEFT/RIGHT auto-repeat. Revision: 1.0
module tetris_input_ctrl
  import enum_type::*;
#(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned DAS_CYCLES  = 20000000,
  parameter int unsigned ARR_CYCLES  = 5000000,
  parameter int unsigned GRAV_CYCLES = 50000000,
  parameter int unsigned GRAV_STEP   = 3000000,
  parameter int unsigned GRAV_MIN    = 5000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      btn,
  input  logic [3:0]      level,
  input  logic            pause,
  input  logic            ctrl_ready,
  output state_type       ctrl,
  output logic            gravity_tick
);

  logic [NUM_BTN-1:0]  btn_level;
  logic [NUM_BTN-1:0]  btn_press;
  logic                rep_left;
  logic                rep_right;
  logic                unused_sig;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[i]),
      .level (btn_level[i]),
      .press (btn_press[i])
    );
  end

`ifdef TETRIS_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(DAS_CYCLES + 1);
  logic [1:0] rep_fire;

  // Counter reloads to DAS-ARR after each repeat so later repeats land every ARR cycles.
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [RW-1:0] rep_cnt;
    assign rep_fire[i] = btn_level[i] && (rep_cnt == RW'(DAS_CYCLES - 1));
    always_ff @(posedge clk) begin
      if (reset || !btn_level[i]) begin
        rep_cnt <= '0;
      end else if (rep_fire[i]) begin
        rep_cnt <= RW'(DAS_CYCLES - ARR_CYCLES);
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign rep_left   = rep_fire[BTN_LEFT];
  assign rep_right  = rep_fire[BTN_RIGHT];
  assign unused_sig = ^btn_level[NUM_BTN-1:2];
`else
  assign rep_left   = 1'b0;
  assign rep_right  = 1'b0;
  assign unused_sig = ^{btn_level, DAS_CYCLES, ARR_CYCLES};
`endif

  logic [31:0] lvl_step;
  logic [31:0] grav_period;
  logic [31:0] grav_cnt;
  logic        grav_fire;

  // A level*step larger than GRAV_CYCLES would go negative, so it clamps too.
  always_comb begin
    lvl_step = 32'(level) * GRAV_STEP;
    if ((lvl_step > GRAV_CYCLES) || ((GRAV_CYCLES - lvl_step) < GRAV_MIN)) begin
      grav_period = GRAV_MIN;
    end else begin
      grav_period = GRAV_CYCLES - lvl_step;
    end
  end

  assign grav_fire = !pause && (grav_cnt >= (grav_period - 32'd1));

  arb_state_t          arb;
  logic [NUM_PEND-1:0] pend;
  logic [NUM_PEND-1:0] grant;
  logic [NUM_PEND-1:0] evt;
  logic [NUM_PEND-1:0] pend_n;
  state_type           grant_cmd;

  always_comb begin
    grant     = '0;
    grant_cmd = NONE;
    if ((arb == ARB_IDLE) && !pause && ctrl_ready) begin
      for (int i = NUM_PEND - 1; i >= 0; i--) begin
        if (pend[i] && (grant == '0)) begin
          grant[i]  = 1'b1;
          grant_cmd = pend_cmd(i);
        end
      end
    end
  end

  always_comb begin
    evt              = '0;
    evt[PEND_HOLD]   = btn_press[BTN_HOLD];
    evt[PEND_DROP]   = btn_press[BTN_DROP];
    evt[PEND_ROTATE] = btn_press[BTN_ROTATE];
    evt[PEND_LEFT]   = btn_press[BTN_LEFT] || rep_left;
    evt[PEND_RIGHT]  = btn_press[BTN_RIGHT] || rep_right;
    evt[PEND_DOWN]   = grav_fire;
    // Event OR'd after the grant clear, so a same-cycle re-arrival stays pending.
    pend_n = (pend & ~grant) | evt;
    if (pause) begin
      pend_n[PEND_DOWN] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= pend_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grav_cnt     <= '0;
      gravity_tick <= 1'b0;
    end else begin
      gravity_tick <= grav_fire;
      if (grav_fire || grant[PEND_DOWN] || grant[PEND_DROP]) begin
        grav_cnt <= '0;
      end else if (!pause) begin
        grav_cnt <= grav_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb  <= ARB_IDLE;
      ctrl <= NONE;
    end else begin
      case (arb)
        ARB_IDLE: begin
          if (grant != '0) begin
            ctrl <= grant_cmd;
            arb  <= ARB_ISSUE;
          end else begin
            ctrl <= NONE;
          end
        end
        ARB_ISSUE: begin
          ctrl <= NONE;
          arb  <= ARB_GAP;
        end
        ARB_GAP: begin
          ctrl <= NONE;
          arb  <= ARB_IDLE;
        end
        default: begin
          ctrl <= NONE;
          arb  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetris_input_ctrl.sv
`default_nettype none
// tb_tetris_input_ctrl: directed + random stimulus against a cycle-level behavioural model.
// Revision: 1.0
module tb_tetris_input_ctrl;
  import enum_type::*;

  localparam int DEB  = 4;
  localparam int DAS  = 20;
  localparam int ARR  = 5;
  localparam int GRAV = 50;
  localparam int STEP = 10;
  localparam int GMIN = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [3:0] level;
  logic       pause;
  logic       ctrl_ready;
  state_type  ctrl;
  logic       gravity_tick;

  always #5 clk = ~clk;

  tetris_input_ctrl #(
    .DEB_CYCLES (DEB),
    .DAS_CYCLES (DAS),
    .ARR_CYCLES (ARR),
    .GRAV_CYCLES(GRAV),
    .GRAV_STEP  (STEP),
    .GRAV_MIN   (GMIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .level       (level),
    .pause       (pause),
    .ctrl_ready  (ctrl_ready),
    .ctrl        (ctrl),
    .gravity_tick(gravity_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: sync pipeline, debounced level, mismatch run length, hold time.
  bit        m_s1   [5];
  bit        m_s2   [5];
  bit        m_lvl  [5];
  int        m_run  [5];
  int        m_held [2];
  bit        m_pend [6];   // indexed by priority rank, 0 = highest
  int        m_g;
  int        m_cool;
  state_type m_ctrl;
  bit        m_tick;

  function automatic state_type rank_cmd(input int r);
    case (r)
      0: rank_cmd = HOLD;
      1: rank_cmd = DROP;
      2: rank_cmd = ROTATE;
      3: rank_cmd = LEFT;
      4: rank_cmd = RIGHT;
      default: rank_cmd = DOWN;
    endcase
  endfunction

  task automatic model_edge();
    bit     press [5];
    bit     rep   [2];
    bit     ev    [6];
    longint p;
    bit     fire;
    int     gi;
    if (reset) begin
      for (int b = 0; b < 5; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
      end
      for (int i = 0; i < 2; i++) m_held[i] = 0;
      for (int r = 0; r < 6; r++) m_pend[r] = 0;
      m_g = 0; m_cool = 0; m_ctrl = NONE; m_tick = 0;
      return;
    end
    for (int i = 0; i < 2; i++) rep[i] = 0;
`ifdef TETRIS_AUTOREPEAT_EN
    for (int i = 0; i < 2; i++) begin
      if (m_lvl[i]) begin
        m_held[i]++;
        rep[i] = (m_held[i] == DAS) || ((m_held[i] > DAS) && (((m_held[i] - DAS) % ARR) == 0));
      end else begin
        m_held[i] = 0;
      end
    end
`endif
    for (int b = 0; b < 5; b++) begin
      press[b] = 0;
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_s2[b];
          m_run[b] = 0;
          press[b] = m_lvl[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    for (int b = 0; b < 5; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
    end
    p = longint'(GRAV) - longint'(level) * longint'(STEP);
    if (p < GMIN) p = GMIN;
    fire = !pause && (longint'(m_g) >= p - 1);
    gi = -1;
    if (m_cool == 0 && !pause && ctrl_ready) begin
      for (int r = 5; r >= 0; r--) if (m_pend[r]) gi = r;
    end
    m_tick = fire;
    if (gi >= 0) begin
      m_ctrl = rank_cmd(gi);
      m_cool = 2;
    end else begin
      m_ctrl = NONE;
      if (m_cool > 0) m_cool--;
    end
    if (fire || (gi >= 0 && (rank_cmd(gi) == DOWN || rank_cmd(gi) == DROP))) m_g = 0;
    else if (!pause) m_g++;
    ev[0] = press[4];
    ev[1] = press[3];
    ev[2] = press[2];
    ev[3] = press[0] | rep[0];
    ev[4] = press[1] | rep[1];
    ev[5] = fire;
    if (gi >= 0) m_pend[gi] = 0;
    for (int r = 0; r < 6; r++) m_pend[r] = m_pend[r] | ev[r];
    if (pause) m_pend[5] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    n_cmp++;
    assert (ctrl === m_ctrl) else begin
      n_bad++;
      $error("FAIL ctrl: observed %0d expected %0d at %0t", ctrl, m_ctrl, $time);
    end
    n_cmp++;
    assert (gravity_tick === m_tick) else begin
      n_bad++;
      $error("FAIL gravity_tick: observed %0b expected %0b at %0t", gravity_tick, m_tick, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, input state_type cmd, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (ctrl == cmd) cnt++;
    end
  endtask

  int          cnt;
  int          cnt2;
  int          delay;
  int          k;
  state_type   seq [$];
  int          hold_left [5];

  initial begin
    reset = 1'b1; btn = '0; level = 4'd0; pause = 1'b0; ctrl_ready = 1'b1;
    repeat (3) step();
    check_int("reset_ctrl_none", int'(ctrl), int'(NONE));
    reset = 1'b0;
    repeat (2) step();

    // ROTATE glitch shorter than the debounce window: nothing issued.
    btn[BTN_ROTATE] = 1'b1;
    repeat (3) step();
    btn[BTN_ROTATE] = 1'b0;
    run_count(10, ROTATE, cnt);
    check_int("rotate_glitch_count", cnt, 0);

    // ROTATE held 10 cycles: exactly one pulse, 6..7 cycles after the raw rise.
    btn[BTN_ROTATE] = 1'b1;
    delay = -1; cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) btn[BTN_ROTATE] = 1'b0;
      step();
      if (ctrl == ROTATE) begin
        cnt++;
        if (delay < 0) delay = i;
      end
    end
    check_int("rotate_held_count", cnt, 1);
    check_int("rotate_latency_ok", int'(delay == 6 || delay == 7), 1);

    // LEFT held: press plus four repeats when auto-repeat is built.
    btn[BTN_LEFT] = 1'b1;
    run_count(36, LEFT, cnt);
    btn[BTN_LEFT] = 1'b0;
    run_count(30, LEFT, cnt2);
`ifdef TETRIS_AUTOREPEAT_EN
    check_int("left_repeat_count", cnt + cnt2, 5);
`else
    check_int("left_single_count", cnt + cnt2, 1);
`endif

    // Simultaneous HOLD, DROP, RIGHT: issued by priority.
    btn[BTN_HOLD] = 1'b1; btn[BTN_DROP] = 1'b1; btn[BTN_RIGHT] = 1'b1;
    seq.delete();
    for (int i = 0; i < 25; i++) begin
      if (i == 8) btn = '0;
      step();
      if (ctrl != NONE && ctrl != DOWN) seq.push_back(ctrl);
    end
    check_int("multi_count", seq.size(), 3);
    if (seq.size() >= 3) begin
      check_int("multi_first", int'(seq[0]), int'(HOLD));
      check_int("multi_second", int'(seq[1]), int'(DROP));
      check_int("multi_third", int'(seq[2]), int'(RIGHT));
    end

    // Gravity at level 0, then level 4 (clamped period).
    level = 4'd0;
    run_count(120, DOWN, cnt);
    check_int("grav_l0_down_count", int'(cnt >= 2 && cnt <= 3), 1);
    level = 4'd4;
    run_count(60, DOWN, cnt);
    check_int("grav_l4_down_count", int'(cnt >= 3 && cnt <= 5), 1);

    // Pause: no ticks, no DOWN.
    pause = 1'b1;
    step(); step(); step();
    cnt2 = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (gravity_tick) cnt2++;
      if (ctrl == DOWN) cnt2++;
    end
    check_int("pause_no_gravity", cnt2, 0);
    pause = 1'b0;
    level = 4'd0;

    // ctrl_ready low while LEFT and ROTATE pressed.
    ctrl_ready = 1'b0;
    btn[BTN_LEFT] = 1'b1; btn[BTN_ROTATE] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ctrl != NONE) cnt++;
    end
    btn = '0;
    check_int("not_ready_quiet", cnt, 0);
    ctrl_ready = 1'b1;
    seq.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (ctrl != NONE && ctrl != DOWN) seq.push_back(ctrl);
    end
    check_int("ready_count", seq.size(), 2);
    if (seq.size() >= 2) begin
      check_int("ready_first", int'(seq[0]), int'(ROTATE));
      check_int("ready_second", int'(seq[1]), int'(LEFT));
    end

    // Reset while DROP pending discards it.
    ctrl_ready = 1'b0;
    btn[BTN_DROP] = 1'b1;
    k = 0;
    while (!m_pend[1] && k < 20) begin
      step();
      k++;
    end
    check_int("drop_pending_reached", int'(m_pend[1]), 1);
    btn = '0;
    reset = 1'b1;
    step();
    check_int("reset_mid_ctrl", int'(ctrl), int'(NONE));
    reset = 1'b0; ctrl_ready = 1'b1;
    run_count(20, DROP, cnt);
    check_int("drop_after_reset", cnt, 0);

    // Random phase.
    for (int b = 0; b < 5; b++) hold_left[b] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold_left[b] == 0) begin
          btn[b] = ($urandom_range(0, 2) == 0);
          hold_left[b] = $urandom_range(1, 40);
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 149) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      ctrl_ready = ($urandom_range(0, 9) < 8);
      reset = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
